// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin burst arbiter.
package mux_rr_arbiter_pkg;

    localparam int unsigned NUM_REQ = 4;

    typedef logic [1:0] req_idx_t;

    typedef enum logic {
        ARB,
        LOCK
    } state_e;

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Rotate-priority pick: first set request bit at ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick_4
    import mux_rr_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  req_idx_t           ptr_i,
    output logic               found_o,
    output req_idx_t           idx_o
);

    req_idx_t cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ptr_i + req_idx_t'(k);
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// 4-requester round-robin arbiter with burst lock and a registered 4:1 output mux.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       in_valid,
    input  logic [3:0]       in_last,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    output logic [3:0]       in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel,
    output logic             out_last
);

    state_e             state_q, state_d;
    req_idx_t           ptr_q, ptr_d;
    req_idx_t           lock_q, lock_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    req_idx_t           out_sel_q, out_sel_d;
    logic               out_last_q, out_last_d;

    logic               pick_found;
    req_idx_t           pick_idx;
    logic               win_found;
    req_idx_t           win_idx;
    logic               win_last;
    logic               load_en;
    logic [WIDTH-1:0]   win_data;

    rr_pick_4 u_pick (
        .req_i   (in_valid),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            ptr_q   <= '0;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
        end
    end

    // Output/decision logic: in LOCK only the lock owner may win
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        unique case (state_q)
            ARB: begin
                win_found = pick_found;
                win_idx   = pick_idx;
            end
            LOCK: begin
                win_found = in_valid[lock_q];
                win_idx   = lock_q;
            end
            default: ;
        endcase
        win_last = in_last[win_idx];
        load_en  = (!out_valid_q || out_ready) && win_found;
        in_ready = (load_en && rst_n) ? (4'b0001 << win_idx) : '0;
    end

    // Next-state logic; ptr advances only on end-of-burst beats
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        ptr_d   = ptr_q;
        if (load_en) begin
            if (win_last) begin
                ptr_d   = win_idx + req_idx_t'(1);
                state_d = ARB;
            end else if (state_q == ARB) begin
                state_d = LOCK;
                lock_d  = win_idx;
            end
        end
    end

    always_comb begin
        unique case (win_idx)
            2'd0:    win_data = in_data0;
            2'd1:    win_data = in_data1;
            2'd2:    win_data = in_data2;
            default: win_data = in_data3;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_last_d  = out_last_q;
        if (load_en) begin
            out_valid_d = 1'b1;
            out_data_d  = win_data;
            out_sel_d   = win_idx;
            out_last_d  = win_last;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomized scoreboard bench for mux_rr_arbiter against a behavioural arbitration model.
module tb_mux_rr_arbiter;

    localparam int unsigned W = 4;

    typedef struct packed {
        logic [W-1:0] data;
        logic [1:0]   sel;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   in_valid, in_last, in_ready;
    logic [W-1:0] dat [4];
    logic         out_valid, out_ready, out_last;
    logic [W-1:0] out_data;
    logic [1:0]   out_sel;

    int n_cmp = 0;
    int n_err = 0;
    exp_t sb[$];

    // Reference model state
    bit m_locked;
    int m_owner, m_ptr;
    bit m_occ;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data0  (dat[0]),
        .in_data1  (dat[1]),
        .in_data2  (dat[2]),
        .in_data3  (dat[3]),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: decides each cycle's load from the arbitration rules and predicts the beat.
    initial forever begin
        @(negedge clk); #4;
        if (!rst_n) begin
            m_locked = 0; m_owner = 0; m_ptr = 0; m_occ = 0;
        end else begin
            int  w;
            bit  found;
            bit  load;
            logic [3:0] exp_rdy;
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_occ});
            found = 0; w = 0;
            if (m_locked) begin
                found = in_valid[m_owner];
                w = m_owner;
            end else begin
                for (int k = 0; k < 4; k++)
                    if (!found && in_valid[(m_ptr + k) % 4]) begin
                        found = 1;
                        w = (m_ptr + k) % 4;
                    end
            end
            load = (!m_occ || out_ready) && found;
            exp_rdy = load ? 4'(1 << w) : 4'd0;
            chk("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
            if (load) begin
                sb.push_back('{data: dat[w], sel: 2'(w), last: in_last[w]});
                m_occ = 1;
                if (in_last[w]) begin
                    m_locked = 0;
                    m_ptr = (w + 1) % 4;
                end else begin
                    m_locked = 1;
                    m_owner = w;
                end
            end else if (out_ready) begin
                m_occ = 0;
            end
        end
    end

    // Monitor: compares each beat the DUT hands downstream
    initial forever begin
        @(negedge clk); #4;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL beat_unexpected at %0t: got sel %0d, expected no beat", $time, out_sel);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(e.data));
                chk("out_sel", 32'(out_sel), 32'(e.sel));
                chk("out_last", {31'd0, out_last}, {31'd0, e.last});
            end
        end
    end

    task automatic chk_reset_outputs();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sel", 32'(out_sel), 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_in_ready", {28'd0, in_ready}, 32'd0);
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic r);
        @(negedge clk);
        in_valid  = v;
        in_last   = l;
        out_ready = r;
        for (int i = 0; i < 4; i++) dat[i] = W'($urandom);
    endtask

    task automatic rand_phase(input int cycles, input int last_pct, input int rdy_pct, input int vld_pct);
        for (int c = 0; c < cycles; c++) begin
            logic [3:0] v, l;
            for (int b = 0; b < 4; b++) begin
                v[b] = ($urandom_range(0, 99) < vld_pct);
                l[b] = ($urandom_range(0, 99) < last_pct);
            end
            drive(v, l, ($urandom_range(0, 99) < rdy_pct));
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = '0; in_last = '0; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) dat[i] = '0;
        in_valid = 4'hF;
        #3;
        chk_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        // Fairness: all requesting, single-beat bursts
        for (int i = 0; i < 8; i++) drive(4'hF, 4'hF, 1'b1);
        // Burst lock then backpressure and lock stall shapes
        drive(4'hF, 4'h0, 1'b1);
        drive(4'hF, 4'h0, 1'b1);
        drive(4'hF, 4'hF, 1'b1);
        for (int i = 0; i < 4; i++) drive(4'hF, 4'hF, 1'b0);
        drive(4'hF, 4'hF, 1'b1);
        rand_phase(150, 70, 80, 60);
        rand_phase(150, 25, 50, 40);
        rand_phase(100, 40, 95, 85);
        // Reset while locked: restart from requester 0
        drive(4'hF, 4'h0, 1'b1);
        drive(4'hF, 4'h0, 1'b1);
        pulse_reset();
        for (int i = 0; i < 4; i++) drive(4'hF, 4'hF, 1'b1);
        rand_phase(150, 50, 70, 50);
        for (int i = 0; i < 3; i++) drive(4'h0, 4'h0, 1'b1);
        @(negedge clk); #6;
        chk("final_queue_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
